// File: rtl/mdu_div_wb.sv
// mdu_div_wb: RV32M DIV/DIVU/REM/REMU restoring divider feeding the register-file write port.
// Latency: 32 cycles from start accept to wb_en (1 cycle for div-by-zero/overflow with DIV_EARLY_OUT_EN).
// Backpressure: none downstream; start is ignored while busy=1 (no queueing); flush aborts in-flight work.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   start, op           request (accepted only when idle and flush=0); 00=DIV 01=DIVU 10=REM 11=REMU
//   rs1_data, rs2_data  dividend / divisor, sampled only in the accept cycle
//   rd_addr             destination register, sampled with start
//   flush               synchronous abort of the in-flight operation (outranks start)
//   busy                high while the unit is not idle
//   wb_en/wb_addr/wb_data  one-cycle register-file write strobe, address and data
//
// Build option: define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow
// cases one cycle after accept instead of running all 32 iterations.

module mdu_div_wb #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RA_W-1:0] rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            wb_en,
    output logic [RA_W-1:0] wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ZERO     = '0;
    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Everything about the accepted operation that is needed again when forming the result.
    typedef struct packed {
        logic [1:0]      opc;
        logic [RA_W-1:0] rd;
        logic            neg1;   // rs1 negative (signed ops only)
        logic            neg2;   // rs2 negative (signed ops only)
        logic            div0;   // divisor was zero
        logic            ovf;    // signed MIN_NEG / -1
    } ctx_t;

    state_t           state;
    ctx_t             ctx;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dvd_q;     // dividend shifts out MSB-first while quotient bits shift in
    logic [XLEN-1:0]  dsr_q;     // |divisor|
    logic [XLEN-1:0]  rem_q;     // partial remainder

    // ---------------- operand capture ----------------
    logic            signed_in;
    logic            neg1_in;
    logic            neg2_in;
    logic            div0_in;
    logic            ovf_in;
    logic [XLEN-1:0] abs1_in;
    logic [XLEN-1:0] abs2_in;

    assign signed_in = ~op[0];
    assign neg1_in   = signed_in & rs1_data[XLEN-1];
    assign neg2_in   = signed_in & rs2_data[XLEN-1];
    assign abs1_in   = neg1_in ? (ZERO - rs1_data) : rs1_data;
    assign abs2_in   = neg2_in ? (ZERO - rs2_data) : rs2_data;
    assign div0_in   = (rs2_data == ZERO);
    assign ovf_in    = signed_in & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);

    // ---------------- one restoring step ----------------
    // The shifted remainder needs one extra bit: it can reach 2*|divisor|-1.
    logic [XLEN:0]   rem_sh;
    logic            q_bit;
    logic [XLEN-1:0] r_step;
    logic [XLEN-1:0] q_step;

    assign rem_sh = {rem_q, dvd_q[XLEN-1]};
    assign q_bit  = (rem_sh >= {1'b0, dsr_q});
    assign r_step = q_bit ? XLEN'(rem_sh - {1'b0, dsr_q}) : rem_sh[XLEN-1:0];
    assign q_step = {dvd_q[XLEN-2:0], q_bit};

    // ---------------- early-out selection ----------------
    logic early_hit;
`ifdef DIV_EARLY_OUT_EN
    assign early_hit = ctx.div0 | ctx.ovf;
`else
    assign early_hit = 1'b0;
`endif

    // ---------------- result formatting ----------------
    // On the iterative path a zero divisor leaves |rs1| in the remainder, and
    // MIN_NEG/-1 naturally yields quotient MIN_NEG, remainder 0. The early-out
    // path skips the iterations, so dvd_q still holds |rs1| and the overflow
    // remainder is forced to zero.
    logic [XLEN-1:0] r_fin;
    logic [XLEN-1:0] result;

    assign r_fin = ctx.ovf ? ZERO : (early_hit ? dvd_q : r_step);

    always_comb begin
        result = ZERO;
        if (ctx.opc[1]) begin
            result = ctx.neg1 ? (ZERO - r_fin) : r_fin;
        end else if (ctx.div0) begin
            result = ALL_ONES;
        end else if (ctx.ovf) begin
            result = MIN_NEG;
        end else begin
            result = (ctx.neg1 ^ ctx.neg2) ? (ZERO - q_step) : q_step;
        end
    end

    // ---------------- FSM and datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ctx     <= '0;
            cnt     <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            busy    <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_en <= 1'b0;
                    if (start && !flush) begin
                        ctx   <= '{opc: op, rd: rd_addr, neg1: neg1_in, neg2: neg2_in,
                                   div0: div0_in, ovf: ovf_in};
                        dvd_q <= abs1_in;
                        dsr_q <= abs2_in;
                        rem_q <= '0;
                        cnt   <= '0;
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        wb_en <= 1'b0;
                    end else if (early_hit) begin
                        state   <= DONE;
                        wb_en   <= (ctx.rd != '0);
                        wb_addr <= ctx.rd;
                        wb_data <= result;
                    end else begin
                        dvd_q <= q_step;
                        rem_q <= r_step;
                        // The final step's result is formatted and written in the same edge.
                        if (cnt == CNT_LAST) begin
                            state   <= DONE;
                            wb_en   <= (ctx.rd != '0);
                            wb_addr <= ctx.rd;
                            wb_data <= result;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wb_en <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wb_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_wb.sv
// tb_mdu_div_wb: self-checking bench for mdu_div_wb against an arithmetic reference model.
// Latency: expected write-back 32 cycles after accept (1 for special cases with DIV_EARLY_OUT_EN).
// Backpressure: exercises start-while-busy, flush (with and without start) and async reset.

module tb_mdu_div_wb;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    mdu_div_wb #(.XLEN(32), .RA_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   if (b == 0) return 32'hFFFF_FFFF;
                     else if (ovf) return 32'h8000_0000;
                     else return sa / sb;
            2'b01:   if (b == 0) return 32'hFFFF_FFFF;
                     else return a / b;
            2'b10:   if (b == 0) return a;
                     else if (ovf) return 32'h0;
                     else return sa % sb;
            default: if (b == 0) return a;
                     else return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 32;
`else
        if (o == 2'b00 && a == 32'h1 && b == 32'h1) return 32;
        return 32;
`endif
    endfunction

    // Issues one operation from idle and observes 36 cycles after the accept edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int pulses,
                          output logic [31:0] d, output logic [4:0] ad);
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
        lat = 0; pulses = 0; d = '0; ad = '0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (wb_en) begin
                pulses++;
                if (lat == 0) begin
                    lat = k; d = wb_data; ad = wb_addr;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        rs1_data = '0; rs2_data = '0; rd_addr = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got=%b exp=0", wb_en); end
        checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL reset_wb_addr got=%0d exp=0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_divu_remu();
        int lat, pulses; logic [31:0] d; logic [4:0] ad;
        run_op(2'b01, 32'd100, 32'd7, 5'd5, lat, pulses, d, ad);
        checks++; if (lat !== 32) begin errors++; $display("FAIL divu_lat got=%0d exp=32", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL divu_pulses got=%0d exp=1", pulses); end
        checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_data got=%h exp=%h", d, 32'd14); end
        checks++; if (ad !== 5'd5) begin errors++; $display("FAIL divu_addr got=%0d exp=5", ad); end
        checks++; if (wb_data !== 32'd14) begin errors++; $display("FAIL divu_hold got=%h exp=%h", wb_data, 32'd14); end
        run_op(2'b11, 32'd100, 32'd7, 5'd5, lat, pulses, d, ad);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_data got=%h exp=%h", d, 32'd2); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL remu_lat got=%0d exp=32", lat); end
    endtask

    task automatic test_signed();
        int lat, pulses; logic [31:0] d; logic [4:0] ad;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, lat, pulses, d, ad);
        checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_data got=%h exp=FFFFFFFD", d); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, lat, pulses, d, ad);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg_data got=%h exp=FFFFFFFF", d); end
    endtask

    task automatic test_special();
        logic [1:0]  t_op  [6] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
        logic [31:0] t_a   [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'd5};
        logic [31:0] t_b   [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] t_exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            int lat, pulses; logic [31:0] d; logic [4:0] ad; int el;
            run_op(t_op[i], t_a[i], t_b[i], 5'd9, lat, pulses, d, ad);
            el = exp_lat(t_op[i], t_a[i], t_b[i]);
            checks++; if (d !== t_exp[i]) begin errors++; $display("FAIL special%0d_data got=%h exp=%h", i, d, t_exp[i]); end
            checks++; if (lat !== el) begin errors++; $display("FAIL special%0d_lat got=%0d exp=%0d", i, lat, el); end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL special%0d_pulses got=%0d exp=1", i, pulses); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int lat, pulses, sel, el; logic [31:0] d, a, b, e; logic [4:0] ad, rd; logic [1:0] o;
            o = 2'($urandom_range(0, 3)); a = $urandom; sel = $urandom_range(0, 9);
            rd = 5'($urandom_range(1, 31));
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel <= 4) b = 32'($urandom_range(1, 15));
            else if (sel == 5) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else b = $urandom;
            run_op(o, a, b, rd, lat, pulses, d, ad);
            e = ref_result(o, a, b); el = exp_lat(o, a, b);
            checks++; if (d !== e) begin errors++; $display("FAIL rand%0d_data op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, d, e); end
            checks++; if (ad !== rd) begin errors++; $display("FAIL rand%0d_addr got=%0d exp=%0d", i, ad, rd); end
            checks++; if (lat !== el) begin errors++; $display("FAIL rand%0d_lat got=%0d exp=%0d", i, lat, el); end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL rand%0d_pulses got=%0d exp=1", i, pulses); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = 0, pulses = 0; logic [31:0] d = '0; logic [4:0] ad = '0;
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr = 5'd7; start = 1'b1; end
            if (k == 6) start = 1'b0;
            if (wb_en) begin
                pulses++;
                if (lat == 0) begin lat = k; d = wb_data; ad = wb_addr; end
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL busy_ignore_lat got=%0d exp=32", lat); end
        checks++; if (d !== 32'd14) begin errors++; $display("FAIL busy_ignore_data got=%h exp=%h", d, 32'd14); end
        checks++; if (ad !== 5'd3) begin errors++; $display("FAIL busy_ignore_addr got=%0d exp=3", ad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        int lat, pulses; logic [31:0] d; logic [4:0] ad;
        // flush in idle together with start: nothing is accepted
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'b01; rs1_data = 32'd40; rs2_data = 32'd4; rd_addr = 5'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        // flush mid-calculation, start also high
        op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
        flush = 1'b1; start = 1'b1; op = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd9;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en got=%b exp=0", wb_en); end
        // fresh operation one cycle later; any leaked pulse from the flushed op shows up here
        run_op(2'b00, 32'd1000, 32'hFFFF_FFF6, 5'd10, lat, pulses, d, ad);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL flush_after_pulses got=%0d exp=1", pulses); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL flush_after_lat got=%0d exp=32", lat); end
        checks++; if (d !== 32'hFFFF_FF9C) begin errors++; $display("FAIL flush_after_data got=%h exp=FFFFFF9C", d); end
    endtask

    task automatic test_rd_zero();
        int pulses = 0; logic b1 = 1'b0, b31 = 1'b0, b33 = 1'b1;
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd8; rs2_data = 32'd2; rd_addr = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (wb_en) pulses++;
            if (k == 1) b1 = busy;
            if (k == 31) b31 = busy;
            if (k == 33) b33 = busy;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rd0_pulses got=%0d exp=0", pulses); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL rd0_busy_early got=%b exp=1", b1); end
        checks++; if (b31 !== 1'b1) begin errors++; $display("FAIL rd0_busy_late got=%b exp=1", b31); end
        checks++; if (b33 !== 1'b0) begin errors++; $display("FAIL rd0_busy_end got=%b exp=0", b33); end
    endtask

    task automatic test_back_to_back();
        int k1 = 0, k2 = 0; logic [31:0] d1 = '0, d2 = '0, e1, e2;
        e1 = ref_result(2'b00, 32'd1000, 32'hFFFF_FFF6);
        e2 = ref_result(2'b11, 32'd1000, 32'd7);
        @(negedge clk);
        op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'hFFFF_FFF6; rd_addr = 5'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40 && k1 == 0; k++) begin
            @(negedge clk);
            if (wb_en) begin k1 = k; d1 = wb_data; end
        end
        checks++; if (k1 !== 32) begin errors++; $display("FAIL b2b_first_lat got=%0d exp=32", k1); end
        checks++; if (d1 !== e1) begin errors++; $display("FAIL b2b_first_data got=%h exp=%h", d1, e1); end
        // issue the second op in the very first cycle busy reads low
        for (int k = 0; k < 5 && busy; k++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop got=%b exp=0", busy); end
        op = 2'b11; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40 && k2 == 0; k++) begin
            @(negedge clk);
            if (wb_en) begin k2 = k; d2 = wb_data; end
        end
        checks++; if (k2 !== 32) begin errors++; $display("FAIL b2b_second_lat got=%0d exp=32", k2); end
        checks++; if (d2 !== e2) begin errors++; $display("FAIL b2b_second_data got=%h exp=%h", d2, e2); end
        for (int k = 0; k < 3; k++) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, pulses = 0; logic [31:0] d; logic [4:0] ad;
        @(negedge clk);
        op = 2'b01; rs1_data = 32'd77; rs2_data = 32'd7; rd_addr = 5'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL areset_wb_en got=%b exp=0", wb_en); end
        checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL areset_wb_addr got=%0d exp=0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL areset_wb_data got=%h exp=0", wb_data); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wb_en) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL areset_pulses got=%0d exp=0", pulses); end
        run_op(2'b01, 32'd77, 32'd7, 5'd13, lat, pulses, d, ad);
        checks++; if (d !== 32'd11) begin errors++; $display("FAIL areset_after_data got=%h exp=%h", d, 32'd11); end
    endtask

    initial begin
        test_reset();
        test_divu_remu();
        test_signed();
        test_special();
        test_random();
        test_busy_ignore();
        test_flush();
        test_rd_zero();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout reached time=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
